timing_counter_param: RTL and testbench
=======================================

// Module: timing_counter_param
// PURPOSE
//   Parametrised successor to the fixed 4-bit timing counter: WIDTH-bit up/down counter
//   with a programmable terminal value (limit), synchronous clear/load, count enable, and
//   free-running (wrap) or one-shot (stop) mode. Sits in the timing module as the
//   period/interval generator. Drives tc as a strobe to downstream sequencing logic.
// PARAMETERS
//   WIDTH      8   counter width in bits (>=2)
//   RESET_VAL  0   value of count after reset_n and clr (must be <= limit in use)
// PORTS
//   clk       in   1      clock; all state updates on rising edge
//   reset_n   in   1      one clock; reset is asynchronous and active-low
//   en        in   1      count enable; one step per clk while high
//   clr       in   1      synchronous clear to RESET_VAL, clears done
//   load      in   1      synchronous load of load_val, clears done
//   load_val  in   WIDTH  value taken on load
//   dir       in   1      1 = count up, 0 = count down
//   mode      in   1      0 = free-running wrap, 1 = one-shot (stop at terminal)
//   limit     in   WIDTH  terminal value for up counting / reload value for down counting
//   count     out  WIDTH  current count (registered)
//   tc        out  1      terminal-count strobe, 1 clk wide (registered)
//   done      out  1      one-shot finished, level, held until clr/load/reset
// BEHAVIOUR
//   - Reset (reset_n low, async): count=RESET_VAL, tc=0, done=0. Held while reset_n low.
//   - Priority per edge: clr > load > en. clr/load force tc=0 that cycle.
//   - Terminal condition T: up: count >= limit; down: count == 0.
//   - en=1, done=0, not T: count +1 (up) or -1 (down), tc=0.
//   - en=1, done=0, T, mode=0: up -> count=0; down -> count=limit; tc=1 for that cycle.
//   - en=1, done=0, T, mode=1: count holds, done=1, tc=1 for that cycle only.
//   - done=1: en ignored, count holds, tc=0 until clr or load.
//   - en=0: count, done hold; tc=0.
//   - tc and the wrapped count appear on the same clock edge (latency 1 from en).
//   - Period in mode 0 = limit+1 enabled clocks, both directions.
//   - limit=0: count stays 0, tc=1 every enabled cycle (mode 0); done on 1st enabled cycle (mode 1).
//   - Loaded value > limit: up wraps to 0 on next enabled step (tc=1); down decrements
//     normally from load value to 0, then reloads limit.
//   - limit, dir, mode sampled every edge; a change takes effect on the next enabled step,
//     no restart. Arithmetic modulo 2^WIDTH; no X on count at any limit/load value.
//   - Async reset mid-count or while done: immediate return to reset values, no tc glitch.
// TESTING
//   1 WIDTH=8, limit=9, mode=0, dir=1, en=1 for 25 clks -> count 0..9,0..9,0..4; tc high
//     exactly on clks 10 and 20 (count=0 those cycles).
//   2 limit=5, mode=1, dir=0, load 5 then en=1 -> 5,4,3,2,1,0, then hold 0; tc one pulse
//     and done=1 on the 6th enabled clk; en held further -> no more tc, count stays 0.
//   3 count=7 running, assert clr and load(load_val=3) same cycle -> count=RESET_VAL,
//     tc=0; next cycle load only -> count=3, done=0.
//   4 limit=4, load_val=200, dir=1, en=1 -> count 200 then 0 with tc=1, then 1..4 normal.
//   5 limit=0, mode=0, en toggling 1,0,1 -> count stays 0; tc = 1,0,1.
//   6 reset_n pulsed low mid-count (count=6, async, between edges) -> count=RESET_VAL,
//     tc=0, done=0 immediately; counting resumes from RESET_VAL after release.

Source files
------------

// File: rtl/timing_counter_param.sv
// WIDTH-bit up/down period/interval counter with programmable terminal value,
// synchronous clear/load, and free-running (wrap) or one-shot (stop) modes.
module timing_counter_param #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             term;

  // Up counting treats anything at or above limit as terminal so an
  // out-of-range load wraps instead of running off to 2^WIDTH.
  assign term = dir ? (count_q >= limit) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    if (clr) begin
      count_d = RESET_VAL;
      done_d  = 1'b0;
    end else if (load) begin
      count_d = load_val;
      done_d  = 1'b0;
    end else if (en && !done_q) begin
      if (!term) begin
        count_d = dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end else begin
        tc_d = 1'b1;
        if (mode) begin
          done_d = 1'b1;
        end else begin
          count_d = dir ? '0 : limit;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_timing_counter_param.sv
// Bench for timing_counter_param: directed scenarios plus randomized traffic,
// every cycle compared against an integer-arithmetic reference model.
module tb_timing_counter_param;

  localparam int unsigned      W   = 8;
  localparam logic [W-1:0]     RV  = '0;
  localparam int               MOD = 1 << W;

  logic         clk;
  logic         reset_n;
  logic         en, clr, load, dir, mode;
  logic [W-1:0] load_val, limit;
  logic [W-1:0] count;
  logic         tc, done;

  int n_vec;
  int n_err;

  int m_cnt;
  bit m_tc;
  bit m_done;

  timing_counter_param #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .mode     (mode),
    .limit    (limit),
    .count    (count),
    .tc       (tc),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference: one clock edge expressed with plain integer arithmetic.
  task automatic model_edge();
    bit at_term;
    m_tc = 1'b0;
    if (clr) begin
      m_cnt  = int'(RV);
      m_done = 1'b0;
    end else if (load) begin
      m_cnt  = int'(load_val);
      m_done = 1'b0;
    end else if (en && !m_done) begin
      at_term = dir ? (m_cnt >= int'(limit)) : (m_cnt == 0);
      if (!at_term) begin
        m_cnt = (m_cnt + (dir ? 1 : -1) + MOD) % MOD;
      end else begin
        m_tc = 1'b1;
        if (mode) m_done = 1'b1;
        else      m_cnt  = dir ? 0 : int'(limit);
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, int'(count), m_cnt);
    chk({tag, ".tc"},    int'(tc),    int'(m_tc));
    chk({tag, ".done"},  int'(done),  int'(m_done));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic e, input logic c, input logic l,
                        input logic [W-1:0] lv, input logic d,
                        input logic m, input logic [W-1:0] lim);
    en = e; clr = c; load = l; load_val = lv; dir = d; mode = m; limit = lim;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    set_in(0, 0, 0, '0, 1, 0, 8'd9);
    m_cnt = int'(RV); m_tc = 0; m_done = 0;
    #12;
    check_all("reset");
    reset_n = 1'b1;

    // 1: up count, limit 9, 25 enabled clocks
    set_in(1, 0, 0, '0, 1, 0, 8'd9);
    for (int i = 1; i <= 25; i++) begin
      tick("t1");
      chk("t1.tc_pos", int'(tc), (i == 10 || i == 20) ? 1 : 0);
    end

    // 2: one-shot down count from loaded 5
    set_in(0, 0, 1, 8'd5, 0, 1, 8'd5);
    tick("t2.load");
    set_in(1, 0, 0, 8'd5, 0, 1, 8'd5);
    for (int i = 1; i <= 9; i++) begin
      tick("t2");
      chk("t2.done_pos", int'(done), (i >= 6) ? 1 : 0);
    end

    // 3: clr beats load, then load alone
    set_in(0, 1, 0, '0, 1, 0, 8'd9);
    tick("t3.clr");
    set_in(1, 0, 0, '0, 1, 0, 8'd9);
    for (int i = 0; i < 7; i++) tick("t3.run");
    chk("t3.count7", int'(count), 7);
    set_in(1, 1, 1, 8'd3, 1, 0, 8'd9);
    tick("t3.both");
    chk("t3.clr_wins", int'(count), int'(RV));
    set_in(1, 0, 1, 8'd3, 1, 0, 8'd9);
    tick("t3.load");
    chk("t3.loaded", int'(count), 3);

    // 4: loaded above limit while counting up
    set_in(0, 0, 1, 8'd200, 1, 0, 8'd4);
    tick("t4.load");
    set_in(1, 0, 0, 8'd200, 1, 0, 8'd4);
    tick("t4.wrap");
    chk("t4.wrap_tc", int'(tc), 1);
    for (int i = 0; i < 6; i++) tick("t4.run");

    // 5: limit 0, en toggling
    set_in(0, 1, 0, '0, 1, 0, 8'd0);
    tick("t5.clr");
    for (int i = 0; i < 3; i++) begin
      en = (i != 1);
      tick("t5");
    end

    // 6: async reset mid-count
    set_in(1, 0, 0, '0, 1, 0, 8'd9);
    for (int i = 0; i < 6; i++) tick("t6.run");
    chk("t6.count6", int'(count), 6);
    #3 reset_n = 1'b0;
    #1;
    m_cnt = int'(RV); m_tc = 0; m_done = 0;
    check_all("t6.async");
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick("t6.resume");

    // Randomized traffic, occasional reset between edges
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      clr  = (r < 3);
      load = (r >= 3 && r < 9);
      en   = ($urandom_range(0, 9) < 8);
      load_val = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 20)) : W'($urandom);
      if ($urandom_range(0, 29) == 0) dir  = ~dir;
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 49) == 0)
        limit = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) begin
        #2 reset_n = 1'b0;
        #1;
        m_cnt = int'(RV); m_tc = 0; m_done = 0;
        check_all("rnd.async");
        #1 reset_n = 1'b1;
      end
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
